uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pin bank of the top-level project between NREQ internal requesters.
- Grants one requester at a time, round-robin.
- Owns uio_oe and inserts bus-turnaround cycles whenever the pin direction changes.
- Caps each grant at a burst limit.
- Sits between the project's internal engines and the uio_in/uio_out/uio_oe pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, beat width; fixed to the uio bank width.
- MAX_BURST, 4, maximum beats per grant (1..15).
- TURNAROUND, 1, cycles with uio_oe=0 inserted on a direction change (1..3).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design-select; low blocks new grants and ends the current grant.
- req  in  NREQ  per-requester transfer request, held for the whole burst.
- req_dir  in  NREQ  per-requester direction: 1=drive pins (out), 0=sample pins (in).
- req_last  in  NREQ  marks the final beat of the requester's burst.
- req_data  in  NREQ*DW  per-requester outbound beat, slice i = bits [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, registered.
- owner  out  3  index of the current or most recent grantee.
- busy  out  1  high in TURN or XFER.
- rd_valid  out  1  one-cycle pulse: rd_data holds a sampled inbound beat.
- rd_data  out  DW  registered inbound beat.
- uio_in  in  8  pin input path.
- uio_out  out  8  pin output path, registered.
- uio_oe  out  8  pin enables, registered; 8'hFF = out, 8'h00 = in.

Behaviour:
- Reset values: gnt=0, owner=0, busy=0, rd_valid=0, rd_data=0, uio_out=0, uio_oe=8'h00, cur_dir=IN, rr_ptr=0, beat_cnt=0, state=IDLE.
- Reset mid-transfer aborts at the next edge and the pins drop to input.
- States:
  - IDLE: arbitrate.
  - TURN: pins tri-stated for TURNAROUND cycles.
  - XFER: grant active.
- IDLE:
  - If ena && |req, pick winner w = first set req at or after rr_ptr (wrapping).
  - Latch dir_w = req_dir[w].
  - If dir_w == cur_dir, go to XFER; otherwise go to TURN.
  - With no request, hold; uio_oe reflects cur_dir (8'hFF if OUT, else 8'h00).
- TURN:
  - uio_oe=8'h00 throughout.
  - After TURNAROUND cycles: cur_dir <= dir_w, go to XFER.
- Grant latency: req sampled in IDLE at edge N gives gnt[w]=1 from N+1 (same direction) or from N+1+TURNAROUND (direction change).
- XFER beats:
  - A beat is any cycle with gnt[w] && req[w].
  - OUT beat: uio_out <= req_data[w], uio_oe=8'hFF; pins change one cycle after the beat.
  - IN beat: rd_data <= uio_in, rd_valid <= 1 the following cycle.
  - beat_cnt increments per beat.
- XFER exit, at the end of the cycle, to IDLE; gnt drops the next cycle:
  - a beat with req_last[w];
  - beat_cnt reaches MAX_BURST;
  - req[w] low (abandon, no beat counted);
  - ena low.
- On exit: rr_ptr <= (w+1) mod NREQ, beat_cnt <= 0.
- Re-arbitration: at least one IDLE cycle between grants, so the same requester cannot hold the bus back-to-back when others are waiting.
- Simultaneous events: req_last together with the MAX_BURST beat terminates once.
- Latched fields: direction and w are latched at arbitration. Changes to req_dir[w] or to other req bits during XFER are ignored.
- uio_out keeps its last value when not driving; it is only meaningful while uio_oe=8'hFF.

Decomposition:
- Package uio_arb_pkg holds:
  - state enum {IDLE, TURN, XFER};
  - DIR_IN=1'b0, DIR_OUT=1'b1;
  - OE_IN=8'h00, OE_OUT=8'hFF.
- One sub-module, rr_picker: combinational round-robin first-set search from rr_ptr, giving one-hot grant and index.

Test Plan:
- Reset, then req=4'b0001, req_dir=0, uio_in=8'h5A, req_last on beat 1 → gnt=0001 one cycle after the request, no TURN, rd_valid pulse with rd_data=8'h5A, uio_oe stays 8'h00.
- From cur_dir=IN, req[2] with dir=1, data 8'hA5, req_last on beat 2 → one TURN cycle (busy=1, gnt=0), then gnt=0100; uio_out=8'hA5 with uio_oe=8'hFF.
- req=4'b1111 held, no req_last, MAX_BURST=4 → grants rotate 0,1,2,3,0; each lasts exactly 4 beats; one IDLE cycle between grants.
- OUT grant followed by IN grant → uio_oe goes 8'hFF to 8'h00 in TURN before the IN grant; no cycle has uio_oe=8'hFF while the IN requester is granted.
- Mid-burst: drop ena → gnt=0 next cycle and no new grant while ena=0. Separately, assert rst → all outputs at reset values next edge, uio_oe=8'h00.
- req_last on beat 4 with MAX_BURST=4, plus req_dir toggled mid-burst → single termination, direction unchanged, rr_ptr advances by one.

Source files
------------

// File: rtl/uio_bus_arbiter_pkg.sv
// uio_arb_pkg: shared types and constants for the uio pin-bank arbiter.
//   arb_state_e : arbiter phase (IDLE arbitrate, TURN tri-state, XFER grant)
//   DIR_IN/OUT  : requester direction encoding (1 = drive pins)
//   OE_IN/OUT   : uio_oe patterns for the two pin directions
//   oe_for_dir  : maps a direction to its uio_oe pattern
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam logic       DIR_IN  = 1'b0;
  localparam logic       DIR_OUT = 1'b1;
  localparam logic [7:0] OE_IN   = 8'h00;
  localparam logic [7:0] OE_OUT  = 8'hFF;
  localparam int         IDX_W   = 3;

  function automatic logic [7:0] oe_for_dir(input logic dir);
    logic [7:0] oe;
    if (dir == DIR_OUT) begin
      oe = OE_OUT;
    end else begin
      oe = OE_IN;
    end
    return oe;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req    : request vector
//   ptr    : index where the search starts (must be < NREQ)
//   valid  : at least one request is set
//   onehot : one-hot of the winner (first set bit at or after ptr, wrapping)
//   idx    : binary index of the winner
import uio_arb_pkg::*;

module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  logic [3:0] sum_s;
  logic [3:0] cand_s;
  logic       hit_s;
  logic       take_s;

  // Walk the candidates in rotated order; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = 3'd0;
    onehot = {NREQ{1'b0}};
    sum_s  = 4'd0;
    cand_s = 4'd0;
    hit_s  = 1'b0;
    take_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s  = {1'b0, ptr} + 4'(k);
      cand_s = (sum_s >= 4'(NREQ)) ? (sum_s - 4'(NREQ)) : sum_s;
      hit_s  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        hit_s = hit_s | (req[i] & (cand_s == 4'(i)));
      end
      take_s = hit_s & ~valid;
      idx    = take_s ? cand_s[2:0] : idx;
      valid  = valid | hit_s;
    end
    for (int i = 0; i < NREQ; i++) begin
      onehot[i] = valid & (idx == 3'(i));
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: shares the 8-bit bidirectional uio bank between NREQ
// requesters, round-robin, one grant at a time, with bus turnaround on
// direction change and a per-grant burst cap.
//   clk, rst      : clock, synchronous active-high reset
//   ena           : design-select; low blocks new grants and ends a grant
//   req/req_dir/req_last/req_data : per-requester request, direction,
//                   last-beat marker and outbound beat (slice i*DW +: DW)
//   gnt, owner    : registered one-hot grant and grantee index
//   busy          : high in TURN or XFER
//   rd_valid, rd_data : registered inbound beat and its one-cycle strobe
//   uio_in/uio_out/uio_oe : pin bank (outputs registered)
import uio_arb_pkg::*;

module uio_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 8,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_dir,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               rd_valid,
  output logic [DW-1:0]      rd_data,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [1:0] TURN_LAST  = 2'(TURNAROUND - 1);

  arb_state_e       state_r, state_nx_s;
  logic             cur_dir_r, cur_dir_nx_s;
  logic             dir_w_r, dir_w_nx_s;
  logic [2:0]       w_r, w_nx_s;
  logic [NREQ-1:0]  gnt_sel_r, gnt_sel_nx_s;
  logic [2:0]       rr_ptr_r, rr_ptr_nx_s;
  logic [3:0]       beat_cnt_r, beat_cnt_nx_s;
  logic [1:0]       turn_cnt_r, turn_cnt_nx_s;
  logic [NREQ-1:0]  gnt_r, gnt_nx_s;
  logic             busy_r, busy_nx_s;
  logic             rd_valid_r, rd_valid_nx_s;
  logic [DW-1:0]    rd_data_r, rd_data_nx_s;
  logic [7:0]       uio_out_r, uio_out_nx_s;
  logic [7:0]       uio_oe_r, uio_oe_nx_s;

  logic             pick_valid_s;
  logic [NREQ-1:0]  pick_onehot_s;
  logic [2:0]       pick_idx_s;
  logic             pick_dir_s;
  logic             req_w_s;
  logic             last_w_s;
  logic [DW-1:0]    data_w_s;
  logic             beat_s;
  logic             xfer_exit_s;
  logic [3:0]       ptr_inc_s;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr_r),
    .valid  (pick_valid_s),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Requester-side views selected by the latched one-hot grant.
  assign pick_dir_s = |(req_dir & pick_onehot_s);
  assign req_w_s    = |(req & gnt_sel_r);
  assign last_w_s   = |(req_last & gnt_sel_r);
  assign beat_s     = ena & req_w_s;
  // Abandon / ena-low exits carry no beat; last-beat and cap exits do,
  // and both together still produce a single exit.
  assign xfer_exit_s = ~beat_s | last_w_s | (beat_cnt_r == BURST_LAST);
  assign ptr_inc_s   = {1'b0, w_r} + 4'd1;

  // AND-OR mux of the granted requester's outbound beat.
  always_comb begin
    data_w_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      data_w_s = data_w_s | (req_data[i*DW +: DW] & {DW{gnt_sel_r[i]}});
    end
  end

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_nx_s    = state_r;
    cur_dir_nx_s  = cur_dir_r;
    dir_w_nx_s    = dir_w_r;
    w_nx_s        = w_r;
    gnt_sel_nx_s  = gnt_sel_r;
    rr_ptr_nx_s   = rr_ptr_r;
    beat_cnt_nx_s = beat_cnt_r;
    turn_cnt_nx_s = turn_cnt_r;
    rd_valid_nx_s = 1'b0;
    rd_data_nx_s  = rd_data_r;
    uio_out_nx_s  = uio_out_r;

    case (state_r)
      IDLE: begin
        if (ena && pick_valid_s) begin
          w_nx_s       = pick_idx_s;
          gnt_sel_nx_s = pick_onehot_s;
          dir_w_nx_s   = pick_dir_s;
          if (pick_dir_s == cur_dir_r) begin
            state_nx_s = XFER;
          end else begin
            state_nx_s    = TURN;
            turn_cnt_nx_s = 2'd0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      TURN: begin
        // Losing ena before the turnaround completes cancels it; the pins
        // fall back to the previous direction and no grant is issued.
        if (!ena) begin
          state_nx_s = IDLE;
        end else if (turn_cnt_r == TURN_LAST) begin
          cur_dir_nx_s = dir_w_r;
          state_nx_s   = XFER;
        end else begin
          turn_cnt_nx_s = turn_cnt_r + 2'd1;
        end
      end
      XFER: begin
        if (beat_s) begin
          beat_cnt_nx_s = beat_cnt_r + 4'd1;
          if (dir_w_r == DIR_OUT) begin
            uio_out_nx_s = data_w_s;
          end else begin
            rd_data_nx_s  = uio_in;
            rd_valid_nx_s = 1'b1;
          end
        end else begin
          beat_cnt_nx_s = beat_cnt_r;
        end
        if (xfer_exit_s) begin
          state_nx_s    = IDLE;
          beat_cnt_nx_s = 4'd0;
          rr_ptr_nx_s   = (ptr_inc_s >= 4'(NREQ)) ? 3'd0 : ptr_inc_s[2:0];
        end else begin
          state_nx_s = XFER;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    gnt_nx_s    = (state_nx_s == XFER) ? gnt_sel_nx_s : {NREQ{1'b0}};
    busy_nx_s   = (state_nx_s != IDLE);
    uio_oe_nx_s = (state_nx_s == TURN) ? OE_IN : oe_for_dir(cur_dir_nx_s);
  end

  // State and output registers; reset aborts any transfer, pins to input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cur_dir_r  <= DIR_IN;
      dir_w_r    <= DIR_IN;
      w_r        <= 3'd0;
      gnt_sel_r  <= {NREQ{1'b0}};
      rr_ptr_r   <= 3'd0;
      beat_cnt_r <= 4'd0;
      turn_cnt_r <= 2'd0;
      gnt_r      <= {NREQ{1'b0}};
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DW{1'b0}};
      uio_out_r  <= 8'h00;
      uio_oe_r   <= OE_IN;
    end else begin
      state_r    <= state_nx_s;
      cur_dir_r  <= cur_dir_nx_s;
      dir_w_r    <= dir_w_nx_s;
      w_r        <= w_nx_s;
      gnt_sel_r  <= gnt_sel_nx_s;
      rr_ptr_r   <= rr_ptr_nx_s;
      beat_cnt_r <= beat_cnt_nx_s;
      turn_cnt_r <= turn_cnt_nx_s;
      gnt_r      <= gnt_nx_s;
      busy_r     <= busy_nx_s;
      rd_valid_r <= rd_valid_nx_s;
      rd_data_r  <= rd_data_nx_s;
      uio_out_r  <= uio_out_nx_s;
      uio_oe_r   <= uio_oe_nx_s;
    end
  end

  assign gnt      = gnt_r;
  assign owner    = w_r;
  assign busy     = busy_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign uio_out  = uio_out_r;
  assign uio_oe   = uio_oe_r;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// model of the arbiter (grant owner, pending turnaround cycles, beat count).
module tb_uio_bus_arbiter;

  localparam int NREQ       = 4;
  localparam int DW         = 8;
  localparam int MAX_BURST  = 4;
  localparam int TURNAROUND = 1;

  logic                clk;
  logic                rst;
  logic                ena;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_dir;
  logic [NREQ-1:0]     req_last;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic [2:0]          owner;
  logic                busy;
  logic                rd_valid;
  logic [DW-1:0]       rd_data;
  logic [7:0]          uio_in;
  logic [7:0]          uio_out;
  logic [7:0]          uio_oe;

  int checks = 0;
  int failures = 0;

  uio_bus_arbiter #(
    .NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .TURNAROUND(TURNAROUND)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dir(req_dir),
    .req_last(req_last), .req_data(req_data), .gnt(gnt), .owner(owner),
    .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              model_valid = 1'b0;
  bit              m_act;       // a grant is in force
  int              m_turn;      // turnaround cycles still to go
  int              m_idx;       // grantee
  bit              m_dir;       // grantee direction (1 = out)
  int              m_beats;
  int              m_ptr;
  bit              m_pins_out;  // current pin direction
  logic [NREQ-1:0] e_gnt;
  logic [2:0]      e_owner;
  logic            e_busy;
  logic            e_rd_valid;
  logic [7:0]      e_rd_data;
  logic [7:0]      e_uio_out;
  logic [7:0]      e_oe;

  task automatic release_bus();
    m_act   = 1'b0;
    m_beats = 0;
    m_ptr   = (m_idx + 1) % NREQ;
  endtask

  task automatic model_step();
    bit found;
    int c;
    if (rst) begin
      m_act = 1'b0; m_turn = 0; m_idx = 0; m_dir = 1'b0; m_beats = 0;
      m_ptr = 0; m_pins_out = 1'b0; e_owner = 3'd0; e_rd_valid = 1'b0;
      e_rd_data = 8'h00; e_uio_out = 8'h00;
      model_valid = 1'b1;
    end else begin
      e_rd_valid = 1'b0;
      if (m_act) begin
        if (ena && req[m_idx]) begin
          m_beats++;
          if (m_dir) begin
            e_uio_out = req_data[m_idx*DW +: DW];
          end else begin
            e_rd_data  = uio_in;
            e_rd_valid = 1'b1;
          end
          if (req_last[m_idx] || m_beats == MAX_BURST) release_bus();
        end else begin
          release_bus();
        end
      end else if (m_turn > 0) begin
        if (!ena) begin
          m_turn = 0;
        end else begin
          m_turn--;
          if (m_turn == 0) begin
            m_pins_out = m_dir;
            m_act      = 1'b1;
          end
        end
      end else if (ena && req != '0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (!found && req[c]) begin
            found = 1'b1;
            m_idx = c;
          end
        end
        m_dir   = req_dir[m_idx];
        e_owner = 3'(m_idx);
        if (m_dir == m_pins_out) m_act = 1'b1;
        else m_turn = TURNAROUND;
      end
    end
    e_gnt = '0;
    if (m_act) e_gnt[m_idx] = 1'b1;
    e_busy = m_act || (m_turn > 0);
    e_oe   = (m_turn > 0) ? 8'h00 : (m_pins_out ? 8'hFF : 8'h00);
  endtask

  always @(posedge clk) model_step();

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_gnt", 32'(gnt), 32'(e_gnt));
      chk("m_owner", 32'(owner), 32'(e_owner));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_rd_valid", 32'(rd_valid), 32'(e_rd_valid));
      chk("m_rd_data", 32'(rd_data), 32'(e_rd_data));
      chk("m_uio_out", 32'(uio_out), 32'(e_uio_out));
      chk("m_uio_oe", 32'(uio_oe), 32'(e_oe));
    end
  end

  task automatic wait_gnt();
    for (int n = 0; n < 10 && gnt == '0; n++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_g;
    int cnt;
    rst = 1'b1; ena = 1'b0; req = '0; req_dir = '0; req_last = '0;
    req_data = '0; uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_oe", 32'(uio_oe), 32'h00);
    chk("rst_uio_out", 32'(uio_out), 32'h00);
    rst = 1'b0; ena = 1'b1;

    // IN burst of one beat, no turnaround.
    req = 4'b0001; req_dir = 4'b0000; uio_in = 8'h5A; req_last = 4'b0001;
    @(negedge clk);
    chk("in_gnt", 32'(gnt), 32'h1);
    chk("in_oe", 32'(uio_oe), 32'h00);
    @(negedge clk);
    chk("in_rd_valid", 32'(rd_valid), 32'h1);
    chk("in_rd_data", 32'(rd_data), 32'h5A);
    chk("in_gnt_drop", 32'(gnt), 32'h0);
    req = '0; req_last = '0;
    @(negedge clk);

    // OUT burst needs one TURN cycle first.
    req = 4'b0100; req_dir = 4'b0100; req_data[23:16] = 8'hA5;
    @(negedge clk);
    chk("turn_busy", 32'(busy), 32'h1);
    chk("turn_gnt", 32'(gnt), 32'h0);
    chk("turn_oe", 32'(uio_oe), 32'h00);
    @(negedge clk);
    chk("out_gnt", 32'(gnt), 32'h4);
    chk("out_oe", 32'(uio_oe), 32'hFF);
    @(negedge clk);
    chk("out_data", 32'(uio_out), 32'hA5);
    req_last = 4'b0100;
    @(negedge clk);
    chk("out_end_gnt", 32'(gnt), 32'h0);
    chk("out_idle_oe", 32'(uio_oe), 32'hFF);
    req = '0; req_last = '0; req_dir = '0;

    // Rotation under full load from a fresh pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt();
      exp_g = 4'b0001 << (g % 4);
      chk("rot_gnt", 32'(gnt), 32'(exp_g));
      cnt = 0;
      while (gnt == exp_g && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      chk("rot_len", 32'(cnt), 32'd4);
      chk("rot_gap", 32'(gnt), 32'h0);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Dropping ena ends the grant and blocks new ones.
    req = 4'b0001;
    wait_gnt();
    chk("ena_gnt", 32'(gnt), 32'h1);
    ena = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ena_low_gnt", 32'(gnt), 32'h0);
      chk("ena_low_busy", 32'(busy), 32'h0);
    end
    ena = 1'b1;
    wait_gnt();
    chk("ena_regnt", 32'(gnt), 32'h1);
    // Reset mid-transfer.
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_gnt", 32'(gnt), 32'h0);
    chk("mrst_oe", 32'(uio_oe), 32'h00);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_owner", 32'(owner), 32'h0);
    chk("mrst_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0; req = '0;

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 24) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 7) == 0) req_dir[i] = ~req_dir[i];
        req_last[i] = ($urandom_range(0, 4) == 0);
      end
      req_data = $urandom;
      uio_in   = 8'($urandom);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
